// File: rtl/div_const_pipe_pkg.sv
// Package for the constant-divisor pipeline family.
// Contents: elaboration-time helpers that size the remainder path and split
// the dividend bits across the compute stages.
package div_const_pkg;

  // Smallest n with 2^n >= value (value >= 1).
  function automatic int clog2(input longint unsigned value);
    int n;
    longint unsigned p;
    n = 32'sd0;
    p = 64'd1;
    while (p < value) begin
      p = p << 1;
      n = n + 32'sd1;
    end
    return n;
  endfunction

  // Number of compute stages needed to retire w bits at bps bits per stage.
  function automatic int num_stages(input int w, input int bps);
    return (w + bps - 32'sd1) / bps;
  endfunction

  // Bits handled by the first compute stage: it absorbs the leftover when
  // w is not a multiple of bps, so every later stage is uniform.
  function automatic int first_stage_bits(input int w, input int bps);
    int rem;
    rem = w % bps;
    return (rem == 32'sd0) ? bps : rem;
  endfunction

endpackage

// File: rtl/div_const_stage.sv
// One compute stage of the constant-divisor pipeline.
// Runs NB steps of restoring division on the incoming partial remainder and
// registers the result when en is high (holds otherwise).
// The dividend and quotient share one W-bit register: each step shifts the
// next dividend bit out of the top and the new quotient bit in at the bottom,
// so after all stages the register holds the full quotient.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   en                      pipeline advance (load) enable
//   prev_valid/xq/r/tag     predecessor stage registers
//   valid/xq/r/tag          this stage's registers
module div_const_stage
  import div_const_pkg::*;
#(
  parameter int unsigned D    = 23,
  parameter int          NB   = 4,
  parameter int          W    = 32,
  parameter int          RW   = 5,
  parameter int          TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            prev_valid,
  input  logic [W-1:0]    prev_xq,
  input  logic [RW-1:0]   prev_r,
  input  logic [TAGW-1:0] prev_tag,
  output logic            valid,
  output logic [W-1:0]    xq,
  output logic [RW-1:0]   r,
  output logic [TAGW-1:0] tag
);

  // One extra bit so 2r+1 (at most 2D-1) never overflows before the compare.
  localparam logic [RW:0] DIV = (RW+1)'(D);

  logic [RW:0]  r_acc_s;
  logic [W-1:0] xq_acc_s;

  // NB-step restoring recurrence, MSB of the remaining dividend first.
  always_comb begin
    r_acc_s  = {1'b0, prev_r};
    xq_acc_s = prev_xq;
    for (int i = 32'sd0; i < NB; i++) begin
      r_acc_s  = {r_acc_s[RW-1:0], xq_acc_s[W-1]};
      xq_acc_s = {xq_acc_s[W-2:0], 1'b0};
      if (r_acc_s >= DIV) begin
        r_acc_s     = r_acc_s - DIV;
        xq_acc_s[0] = 1'b1;
      end else begin
        xq_acc_s[0] = 1'b0;
      end
    end
  end

  // Stage register; a registered remainder is always below D, so the top
  // bit of the accumulator is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      xq    <= {W{1'b0}};
      r     <= {RW{1'b0}};
      tag   <= {TAGW{1'b0}};
    end else if (en) begin
      valid <= prev_valid;
      xq    <= xq_acc_s;
      r     <= r_acc_s[RW-1:0];
      tag   <= prev_tag;
    end else begin
      valid <= valid;
      xq    <= xq;
      r     <= r;
      tag   <= tag;
    end
  end

endmodule

// File: rtl/div_const_pipe.sv
// Fully pipelined unsigned divider by the constant D.
// Returns floor(in_x / D) and in_x mod D, NST+1 cycles after acceptance when
// not stalled. The whole pipeline advances in lock-step: it moves when the
// output register is empty or being drained, and holds otherwise (bubbles are
// not squeezed out).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   in_valid/in_ready upstream handshake; in_x dividend, in_tag sideband
//   out_valid/out_ready downstream handshake
//   out_q, out_r      quotient (W bits), remainder (clog2(D) bits)
//   out_tag           tag of the operand that produced this result
module div_const_pipe
  import div_const_pkg::*;
#(
  parameter int          W    = 32,
  parameter int unsigned D    = 23,
  parameter int          BPS  = 4,
  parameter int          TAGW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_x,
  input  logic [TAGW-1:0]     in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_q,
  output logic [clog2(D)-1:0] out_r,
  output logic [TAGW-1:0]     out_tag
);

  localparam int NST = num_stages(W, BPS);
  localparam int RW  = clog2(D);
  localparam int FSB = first_stage_bits(W, BPS);

  if ((D < 32'd2) || (64'(D) >= (64'd1 << W)) || (BPS < 32'sd1) || (BPS > W)) begin : g_bad_param
    $error("div_const_pipe: illegal parameters (need 2 <= D < 2^W, 1 <= BPS <= W)");
  end

  logic            advance_s;
  logic            cap_valid_r;
  logic [W-1:0]    cap_x_r;
  logic [TAGW-1:0] cap_tag_r;

  // Index 0 is the capture register, index NST the output register.
  logic            stg_valid_s [0:NST];
  logic [W-1:0]    stg_xq_s    [0:NST];
  logic [RW-1:0]   stg_r_s     [0:NST];
  logic [TAGW-1:0] stg_tag_s   [0:NST];

  assign advance_s = !stg_valid_s[NST] || out_ready;
  assign in_ready  = advance_s;

  // Operand capture; x and tag are only sampled when an operand is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid_r <= 1'b0;
      cap_x_r     <= {W{1'b0}};
      cap_tag_r   <= {TAGW{1'b0}};
    end else if (advance_s) begin
      cap_valid_r <= in_valid;
      if (in_valid) begin
        cap_x_r   <= in_x;
        cap_tag_r <= in_tag;
      end else begin
        cap_x_r   <= cap_x_r;
        cap_tag_r <= cap_tag_r;
      end
    end else begin
      cap_valid_r <= cap_valid_r;
      cap_x_r     <= cap_x_r;
      cap_tag_r   <= cap_tag_r;
    end
  end

  assign stg_valid_s[0] = cap_valid_r;
  assign stg_xq_s[0]    = cap_x_r;
  assign stg_r_s[0]     = {RW{1'b0}};
  assign stg_tag_s[0]   = cap_tag_r;

  for (genvar k = 1; k <= NST; k++) begin : g_stage
    // The first stage takes the leftover bits so later stages stay uniform.
    localparam int NB = (k == 32'sd1) ? FSB : BPS;

    div_const_stage #(
      .D   (D),
      .NB  (NB),
      .W   (W),
      .RW  (RW),
      .TAGW(TAGW)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (advance_s),
      .prev_valid(stg_valid_s[k-1]),
      .prev_xq   (stg_xq_s[k-1]),
      .prev_r    (stg_r_s[k-1]),
      .prev_tag  (stg_tag_s[k-1]),
      .valid     (stg_valid_s[k]),
      .xq        (stg_xq_s[k]),
      .r         (stg_r_s[k]),
      .tag       (stg_tag_s[k])
    );
  end

  assign out_valid = stg_valid_s[NST];
  assign out_q     = stg_xq_s[NST];
  assign out_r     = stg_r_s[NST];
  assign out_tag   = stg_tag_s[NST];

endmodule

// File: tb/tb_div_const_pipe.sv
// Self-checking bench for div_const_pipe: default configuration plus the
// (W=16, D=7, BPS=3) and (W=8, D=255, BPS=8) configurations.
// The reference model is a lock-step queue of LAT result slots whose contents
// are computed with plain / and %; it moves only when the output slot is empty
// or being drained.
module tb_div_const_pipe;

  localparam int LAT0 = 9;
  localparam int LAT1 = 7;
  localparam int LAT2 = 2;
  localparam int D0 = 23;
  localparam int D1 = 7;
  localparam int D2 = 255;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [31:0] in_x0, out_q0;
  logic [3:0]  in_tag0, out_tag0;
  logic [4:0]  out_r0;

  logic        rst_n1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [15:0] in_x1, out_q1;
  logic [3:0]  in_tag1, out_tag1;
  logic [2:0]  out_r1;

  logic        rst_n2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [7:0]  in_x2, out_q2;
  logic [3:0]  in_tag2, out_tag2;
  logic [7:0]  out_r2;

  div_const_pipe u_dut0 (
    .clk(clk), .rst_n(rst_n0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_x(in_x0), .in_tag(in_tag0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_q(out_q0), .out_r(out_r0), .out_tag(out_tag0));

  div_const_pipe #(.W(16), .D(7), .BPS(3), .TAGW(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_x(in_x1), .in_tag(in_tag1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_q(out_q1), .out_r(out_r1), .out_tag(out_tag1));

  div_const_pipe #(.W(8), .D(255), .BPS(8), .TAGW(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_x(in_x2), .in_tag(in_tag2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_q(out_q2), .out_r(out_r2), .out_tag(out_tag2));

  typedef struct packed {
    logic        v;
    logic [31:0] q;
    logic [7:0]  r;
    logic [3:0]  tag;
  } exp_t;

  exp_t p0 [LAT0];
  exp_t p1 [LAT1];
  exp_t p2 [LAT2];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic exp_t mk(input logic v, input longint unsigned x,
                              input longint unsigned d, input logic [3:0] tag);
    exp_t e;
    e.v   = v;
    e.q   = 32'(x / d);
    e.r   = 8'(x % d);
    e.tag = tag;
    return e;
  endfunction

  function void m0_clear();
    for (int i = 0; i < LAT0; i++) p0[i] = '0;
  endfunction
  function void m1_clear();
    for (int i = 0; i < LAT1; i++) p1[i] = '0;
  endfunction
  function void m2_clear();
    for (int i = 0; i < LAT2; i++) p2[i] = '0;
  endfunction

  function void m0_step(input exp_t e, input logic ordy);
    if (!p0[LAT0-1].v || ordy) begin
      for (int i = LAT0 - 1; i > 0; i--) p0[i] = p0[i-1];
      p0[0] = e;
    end
  endfunction
  function void m1_step(input exp_t e);
    for (int i = LAT1 - 1; i > 0; i--) p1[i] = p1[i-1];
    p1[0] = e;
  endfunction
  function void m2_step(input exp_t e);
    for (int i = LAT2 - 1; i > 0; i--) p2[i] = p2[i-1];
    p2[0] = e;
  endfunction

  function automatic logic m0_busy();
    logic b;
    b = 1'b0;
    for (int i = 0; i < LAT0; i++) b = b | p0[i].v;
    return b;
  endfunction

  task automatic test_reset();
    rst_n0 = 1'b0; rst_n1 = 1'b0; rst_n2 = 1'b0;
    in_valid0 = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
    in_x0 = 32'd0; in_x1 = 16'd0; in_x2 = 8'd0;
    in_tag0 = 4'd0; in_tag1 = 4'd0; in_tag2 = 4'd0;
    out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out_valid0, out_q0, out_r0, out_tag0} !== 42'd0) begin
      n_fail++; $display("FAIL reset_out0: got %h expected 0", {out_valid0, out_q0, out_r0, out_tag0});
    end
    n_checks++;
    if (in_ready0 !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready0: got %b expected 1", in_ready0);
    end
    n_checks++;
    if ({out_valid1, out_q1, out_r1, out_valid2, out_q2, out_r2} !== 37'd0) begin
      n_fail++; $display("FAIL reset_out12: got %h expected 0", {out_valid1, out_q1, out_r1, out_valid2, out_q2, out_r2});
    end
    rst_n0 = 1'b1; rst_n1 = 1'b1; rst_n2 = 1'b1;
    m0_clear(); m1_clear(); m2_clear();
    @(negedge clk);
    n_checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
      n_fail++; $display("FAIL post_reset0: got valid=%b ready=%b expected valid=0 ready=1", out_valid0, in_ready0);
    end
  endtask

  // Four directed operands; results must appear on cycles 9..12 back to back.
  task automatic test_directed();
    logic [31:0] xs [4];
    logic [31:0] eq [4];
    logic [4:0]  er [4];
    logic        exp_v;
    xs = '{32'd22, 32'd23, 32'd1000000, 32'hFFFF_FFFF};
    eq = '{32'd0, 32'd1, 32'd43478, 32'd186737708};
    er = '{5'd22, 5'd0, 5'd6, 5'd11};
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      exp_v = (c >= 9) && (c <= 12);
      n_checks++;
      if (out_valid0 !== exp_v) begin
        n_fail++; $display("FAIL directed_valid c=%0d: got %b expected %b", c, out_valid0, exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (out_q0 !== eq[c-9] || out_r0 !== er[c-9] || out_tag0 !== 4'(c - 8)) begin
          n_fail++;
          $display("FAIL directed_result c=%0d: got q=%0d r=%0d tag=%0d expected q=%0d r=%0d tag=%0d",
                   c, out_q0, out_r0, out_tag0, eq[c-9], er[c-9], c - 8);
        end
      end
      out_ready0 = 1'b1;
      if (c < 4) begin
        in_valid0 = 1'b1; in_x0 = xs[c]; in_tag0 = 4'(c + 1);
      end else begin
        in_valid0 = 1'b0; in_x0 = 32'd0; in_tag0 = 4'd0;
      end
    end
  endtask

  // Generic traffic against the slot model: random or edge operands,
  // configurable valid and ready densities.
  task automatic test_traffic(input string name, input int n, input int rdy_pct,
                              input int vld_pct, input bit edges);
    logic [31:0] edge_v [4];
    logic [31:0] x;
    logic [3:0]  tag;
    logic        iv, ordy;
    int          sent, guard;
    edge_v = '{32'd0, 32'd22, 32'd23, 32'hFFFF_FFFF};
    sent = 0; guard = 0;
    m0_clear();
    while ((sent < n || m0_busy()) && guard < n * 20 + 200) begin
      @(negedge clk);
      guard++;
      n_checks++;
      if (out_valid0 !== p0[LAT0-1].v) begin
        n_fail++; $display("FAIL %s_valid: got %b expected %b", name, out_valid0, p0[LAT0-1].v);
      end
      if (p0[LAT0-1].v) begin
        n_checks++;
        if (out_q0 !== p0[LAT0-1].q || out_r0 !== p0[LAT0-1].r[4:0] || out_tag0 !== p0[LAT0-1].tag) begin
          n_fail++;
          $display("FAIL %s_result: got q=%0d r=%0d tag=%0d expected q=%0d r=%0d tag=%0d", name,
                   out_q0, out_r0, out_tag0, p0[LAT0-1].q, p0[LAT0-1].r, p0[LAT0-1].tag);
        end
        n_checks++;
        if (out_r0 >= 5'd23) begin
          n_fail++; $display("FAIL %s_r_range: got r=%0d expected below 23", name, out_r0);
        end
      end
      ordy = (int'($urandom_range(99, 0)) < rdy_pct);
      iv   = (sent < n) && (int'($urandom_range(99, 0)) < vld_pct);
      if (edges) x = edge_v[sent % 4];
      else if ($urandom_range(7, 0) == 0) x = 32'($urandom_range(50, 0));
      else x = $urandom;
      tag = 4'($urandom);
      in_valid0 = iv; in_x0 = x; in_tag0 = tag; out_ready0 = ordy;
      #1;
      n_checks++;
      if (in_ready0 !== (!p0[LAT0-1].v || ordy)) begin
        n_fail++; $display("FAIL %s_in_ready: got %b expected %b", name, in_ready0, !p0[LAT0-1].v || ordy);
      end
      if (iv && (!p0[LAT0-1].v || ordy)) sent++;
      m0_step(mk(iv, {32'd0, x}, 64'(D0), tag), ordy);
    end
    if (guard >= n * 20 + 200) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got sent=%0d expected %0d and an empty pipe", name, sent, n);
    end
    in_valid0 = 1'b0; out_ready0 = 1'b1;
  endtask

  // Asynchronous reset while results are draining, then one fresh operand.
  task automatic test_reset_mid();
    logic [31:0] x;
    m0_clear();
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid0 !== p0[LAT0-1].v || (p0[LAT0-1].v && out_q0 !== p0[LAT0-1].q)) begin
        n_fail++; $display("FAIL rstmid_pre c=%0d: got valid=%b q=%0d expected valid=%b q=%0d",
                           c, out_valid0, out_q0, p0[LAT0-1].v, p0[LAT0-1].q);
      end
      if (c == 11) break;
      x = $urandom;
      in_valid0 = (c < 9); in_x0 = x; in_tag0 = 4'(c); out_ready0 = 1'b1;
      m0_step(mk(c < 9, {32'd0, x}, 64'(D0), 4'(c)), 1'b1);
    end
    in_valid0 = 1'b0;
    #2 rst_n0 = 1'b0;
    #1;
    n_checks++;
    if ({out_valid0, out_q0, out_r0, out_tag0} !== 42'd0 || in_ready0 !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_async: got out=%h in_ready=%b expected 0 and 1",
                         {out_valid0, out_q0, out_r0, out_tag0}, in_ready0);
    end
    repeat (2) @(negedge clk);
    rst_n0 = 1'b1;
    m0_clear();
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      n_checks++;
      if (out_valid0 !== (c == 9)) begin
        n_fail++; $display("FAIL rstmid_valid c=%0d: got %b expected %b", c, out_valid0, c == 9);
      end
      if (c == 9) begin
        n_checks++;
        if (out_q0 !== 32'd2 || out_r0 !== 5'd0 || out_tag0 !== 4'd5) begin
          n_fail++; $display("FAIL rstmid_result: got q=%0d r=%0d tag=%0d expected q=2 r=0 tag=5",
                             out_q0, out_r0, out_tag0);
        end
      end
      in_valid0 = (c == 0); in_x0 = 32'd46; in_tag0 = 4'd5; out_ready0 = 1'b1;
    end
    in_valid0 = 1'b0;
  endtask

  // Every 16-bit dividend through the W=16, D=7, BPS=3 instance.
  task automatic test_sweep16();
    m1_clear();
    for (int c = 0; c < 65536 + LAT1; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid1 !== p1[LAT1-1].v) begin
        n_fail++; $display("FAIL sweep16_valid c=%0d: got %b expected %b", c, out_valid1, p1[LAT1-1].v);
      end
      if (p1[LAT1-1].v) begin
        n_checks++;
        if (out_q1 !== p1[LAT1-1].q[15:0] || out_r1 !== p1[LAT1-1].r[2:0] ||
            out_tag1 !== p1[LAT1-1].tag || out_r1 >= 3'd7) begin
          n_fail++; $display("FAIL sweep16_result c=%0d: got q=%0d r=%0d expected q=%0d r=%0d",
                             c, out_q1, out_r1, p1[LAT1-1].q, p1[LAT1-1].r);
        end
      end
      in_valid1 = (c < 65536); in_x1 = 16'(c); in_tag1 = 4'(c); out_ready1 = 1'b1;
      m1_step(mk(c < 65536, 64'(c & 32'hFFFF), 64'(D1), 4'(c)));
    end
    in_valid1 = 1'b0;
  endtask

  // Every 8-bit dividend through the W=8, D=255, BPS=8 instance.
  task automatic test_sweep8();
    m2_clear();
    for (int c = 0; c < 256 + LAT2; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid2 !== p2[LAT2-1].v) begin
        n_fail++; $display("FAIL sweep8_valid c=%0d: got %b expected %b", c, out_valid2, p2[LAT2-1].v);
      end
      if (p2[LAT2-1].v) begin
        n_checks++;
        if (out_q2 !== p2[LAT2-1].q[7:0] || out_r2 !== p2[LAT2-1].r ||
            out_tag2 !== p2[LAT2-1].tag || out_r2 >= 8'd255) begin
          n_fail++; $display("FAIL sweep8_result c=%0d: got q=%0d r=%0d expected q=%0d r=%0d",
                             c, out_q2, out_r2, p2[LAT2-1].q, p2[LAT2-1].r);
        end
      end
      in_valid2 = (c < 256); in_x2 = 8'(c); in_tag2 = 4'(c); out_ready2 = 1'b1;
      m2_step(mk(c < 256, 64'(c & 32'hFF), 64'(D2), 4'(c)));
    end
    in_valid2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_traffic("stream", 1000, 100, 100, 1'b0);
    test_traffic("backpressure", 400, 50, 60, 1'b0);
    test_traffic("edges", 8, 100, 100, 1'b1);
    test_traffic("edges_stall", 8, 40, 100, 1'b1);
    test_reset_mid();
    test_sweep16();
    test_sweep8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
